sram_ctr_ahb_fsm: RTL and testbench
===================================

// Module: sram_ctr_ahb_fsm
// PURPOSE
//  Transfer-control FSM of the AHB-Lite SRAM controller, feeding and consuming the error-check stage.
//  Drives the 2-bit state that error check consumes, takes back error_check, and issues single-port sync SRAM accesses.
//  Generates hready_out/hresp, including the two-cycle ERROR response, and the write->read turnaround wait.
// PARAMETERS
//  ADDR_W  12  SRAM word-address width (sram_addr = haddr[ADDR_W+1:2])
//  DATA_W  32  AHB/SRAM data width
// PORTS
//  hclk         in   1       AHB clock; all flops rising edge
//  hresetn      in   1       async active-low reset
//  hsel         in   1       slave select
//  hready_in    in   1       bus HREADY (previous transfer complete)
//  htrans       in   2       00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  hwrite       in   1       1 = write
//  haddr        in   32      address-phase address
//  hwdata       in   DATA_W  write data (data phase)
//  error_check  in   1       combinational error flag from the error-check stage (same cycle)
//  state        out  2       00 IDLE, 01 WRITE, 11 WR2RD, 10 READ (to error-check stage)
//  hready_out   out  1       slave HREADYOUT
//  hresp        out  1       0 OKAY, 1 ERROR
//  hrdata       out  DATA_W  read data = sram_rdata
//  sram_cs      out  1       SRAM chip select (active high)
//  sram_we      out  1       SRAM write enable (active high, valid with sram_cs)
//  sram_addr    out  ADDR_W  SRAM word address
//  sram_wdata   out  DATA_W  SRAM write data = hwdata
//  sram_rdata   in   DATA_W  SRAM read data, one cycle after read cs
// BEHAVIOUR
//  - ap = hsel & hready_in & htrans[1]; ap_ok = ap & ~error_check; ap_err = hsel & hready_in & error_check.
//  - Reset: state=IDLE, resp phase OKAY, hready_out=1, hresp=0, latched wr/rd addr=0, hwrite_q=0.
//    Reset mid-transfer aborts at once: no pending SRAM write issued, sram_cs=0 combinationally.
//  - SRAM drive (combinational, priority order):
//    state==WRITE: cs=1, we=1, addr=wr_addr_q.
//    state==WR2RD: cs=1, we=0, addr=rd_addr_q.
//    else if ap_ok & ~hwrite & state!=WRITE: cs=1, we=0, addr=haddr[ADDR_W+1:2].
//    else cs=0, we=0, addr=0.
//  - Transitions (registered; resp phase OKAY or ERR2):
//    IDLE/READ: ap_ok&hwrite -> WRITE, latch wr_addr_q; ap_ok&~hwrite -> READ; else -> IDLE.
//    WRITE: ap_ok&hwrite -> WRITE (new wr_addr_q);
//           ap_ok&~hwrite -> WR2RD, latch rd_addr_q (SRAM port busy with write data phase);
//           else -> IDLE.
//    WR2RD: -> READ unconditionally (hready_out=0, so no new address phase).
//    ap_err from any state -> IDLE, resp phase -> ERR1; no SRAM access issued for the errored transfer.
//  - Resp sub-FSM OKAY->ERR1->ERR2->OKAY:
//    ERR1: hready_out=0, hresp=1.
//    ERR2: hready_out=1, hresp=1; address phase sampled normally (new ap / new error allowed).
//  - hready_out=0 only in WR2RD and ERR1; hresp=1 only in ERR1/ERR2.
//  - Latency: write zero-wait; read zero-wait, or 1 wait when directly after write; error always 2 cycles.
//  - BUSY/IDLE htrans with no error: no access, state -> IDLE (BUSY mid-burst treated as idle slot).
//  - hrdata valid only in READ data phase; undefined otherwise.
//  - hsel=0 or hready_in=0: ap ignored, WRITE/READ complete and return to IDLE.
// CONFIGURATION
//  SRAM_CTR_ERR_CNT_EN defined: adds output err_cnt[15:0].
//    Reset 0; +1 on each ap_err cycle; saturates at 16'hFFFF.
//  Undefined: no err_cnt port, no counter logic; all other behaviour identical.
// TESTING
//  1 NONSEQ write haddr=0x10, hwdata=0xA5A5A5A5 -> next cycle state=01, cs=1, we=1, addr=4,
//    wdata=A5A5A5A5, hready_out=1.
//  2 Write 0x20 (0x12345678) then NONSEQ read 0x20 back-to-back -> WR2RD 1 cycle: hready_out=0, cs=1, we=0, addr=8;
//    READ cycle: hrdata=12345678, hready_out=1.
//  3 NONSEQ haddr=0x2 (error_check=1) -> sram_cs never 1; +1: hready_out=0, hresp=1;
//    +2: hready_out=1, hresp=1; +3: hresp=0, state=00.
//  4 SEQ while state=IDLE (error_check=1) -> ERROR two-cycle response, state stays 00, no SRAM access.
//  5 hresetn low during WR2RD -> state=00, hready_out=1, hresp=0, cs=0 without clock edge; rd pending dropped.
//  6 SRAM_CTR_ERR_CNT_EN: 3 errored NONSEQ -> err_cnt=3; preload 0xFFFF + 1 error -> stays 0xFFFF.

Source files
------------

// File: rtl/sram_ctr_ahb_fsm.sv
// Transfer-control FSM of the AHB-Lite SRAM controller: SRAM access sequencing, HREADYOUT/HRESP, write->read turnaround.
// Optional build macro SRAM_CTR_ERR_CNT_EN adds a saturating 16-bit errored-transfer counter output err_cnt.
module sram_ctr_ahb_fsm #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hsel,
    input  logic              hready_in,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [31:0]       haddr,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              error_check,
    output logic [1:0]        state,
    output logic              hready_out,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
`ifdef SRAM_CTR_ERR_CNT_EN
    ,
    output logic [15:0]       err_cnt
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_WRITE = 2'b01;
    localparam logic [1:0] ST_WR2RD = 2'b11;
    localparam logic [1:0] ST_READ  = 2'b10;

    localparam logic [1:0] RS_OKAY = 2'b00;
    localparam logic [1:0] RS_ERR1 = 2'b01;
    localparam logic [1:0] RS_ERR2 = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [1:0]        resp_q, resp_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              hwrite_q, hwrite_d;

    logic              ap_open;
    logic              ap;
    logic              ap_ok;
    logic              ap_err;
    logic [ADDR_W-1:0] acc_addr;

    // Byte-lane and low-order address bits plus the BUSY/SEQ distinction carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{haddr[31:ADDR_W+2], haddr[1:0], htrans[0]};

    // A new address phase can only be accepted while this slave is signalling ready.
    assign ap_open  = hready_out;
    assign ap       = hsel & hready_in & htrans[1] & ap_open;
    assign ap_ok    = ap & ~error_check;
    assign ap_err   = hsel & hready_in & error_check & ap_open;
    assign acc_addr = haddr[ADDR_W+1:2];

    assign state      = state_q;
    assign hready_out = (state_q != ST_WR2RD) && (resp_q != RS_ERR1);
    assign hresp      = (resp_q != RS_OKAY);
    assign hrdata     = sram_rdata;
    assign sram_wdata = hwdata;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        resp_d    = RS_OKAY;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        hwrite_d  = hwrite_q;

        if (resp_q == RS_ERR1) begin
            resp_d = RS_ERR2;
        end

        if (ap_err) begin
            state_d = ST_IDLE;
            resp_d  = RS_ERR1;
        end else if (state_q == ST_WR2RD) begin
            state_d = ST_READ;
        end else if (ap_ok) begin
            hwrite_d = hwrite;
            if (hwrite) begin
                state_d   = ST_WRITE;
                wr_addr_d = acc_addr;
            end else if (state_q == ST_WRITE) begin
                // SRAM port is taken by the pending write data phase; defer the read one cycle.
                state_d   = ST_WR2RD;
                rd_addr_d = acc_addr;
            end else begin
                state_d = ST_READ;
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        sram_cs   = 1'b0;
        sram_we   = 1'b0;
        sram_addr = '0;
        // Reset kills any access immediately, without waiting for a clock edge.
        if (!hresetn) begin
            sram_cs = 1'b0;
        end else if (state_q == ST_WRITE) begin
            sram_cs   = 1'b1;
            sram_we   = hwrite_q;
            sram_addr = wr_addr_q;
        end else if (state_q == ST_WR2RD) begin
            sram_cs   = 1'b1;
            sram_addr = rd_addr_q;
        end else if (ap_ok && !hwrite) begin
            sram_cs   = 1'b1;
            sram_addr = acc_addr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q   <= ST_IDLE;
            resp_q    <= RS_OKAY;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            hwrite_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            resp_q    <= resp_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            hwrite_q  <= hwrite_d;
        end
    end

`ifdef SRAM_CTR_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (ap_err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            err_cnt_q <= 16'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_sram_ctr_ahb_fsm.sv
// Self-checking bench for sram_ctr_ahb_fsm: per-cycle expectations queued by each scenario, compared by a negedge monitor.
// Build with SRAM_CTR_ERR_CNT_EN defined to also exercise the error counter.
module tb_sram_ctr_ahb_fsm;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_WRITE = 2'b01;
    localparam logic [1:0] S_WR2RD = 2'b11;
    localparam logic [1:0] S_READ  = 2'b10;

    logic              hclk;
    logic              hresetn;
    logic              hsel;
    logic              hready_in;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [31:0]       haddr;
    logic [DATA_W-1:0] hwdata;
    logic              error_check;
    logic [1:0]        state;
    logic              hready_out;
    logic              hresp;
    logic [DATA_W-1:0] hrdata;
    logic              sram_cs;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
`ifdef SRAM_CTR_ERR_CNT_EN
    logic [15:0]       err_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [1:0]  st;
        logic        rdy;
        logic        resp;
        logic        cs;
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        chk_w;
        logic [31:0] rdata;
        logic        chk_r;
    } exp_t;

    exp_t exp_q[$];

    sram_ctr_ahb_fsm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .hsel        (hsel),
        .hready_in   (hready_in),
        .htrans      (htrans),
        .hwrite      (hwrite),
        .haddr       (haddr),
        .hwdata      (hwdata),
        .error_check (error_check),
        .state       (state),
        .hready_out  (hready_out),
        .hresp       (hresp),
        .hrdata      (hrdata),
        .sram_cs     (sram_cs),
        .sram_we     (sram_we),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata)
`ifdef SRAM_CTR_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Single-port synchronous SRAM: read data appears one cycle after a read select.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge hclk) begin
        if (sram_cs) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         sram_rdata     <= mem[sram_addr];
        end
    end

    always @(negedge hclk) begin
        if (exp_q.size() != 0) begin
            automatic exp_t e = exp_q.pop_front();
            n_checks++;
            if (state !== e.st) begin
                n_errors++;
                $display("FAIL %s.state: got %b expected %b", e.tag, state, e.st);
            end
            n_checks++;
            if (hready_out !== e.rdy) begin
                n_errors++;
                $display("FAIL %s.hready_out: got %b expected %b", e.tag, hready_out, e.rdy);
            end
            n_checks++;
            if (hresp !== e.resp) begin
                n_errors++;
                $display("FAIL %s.hresp: got %b expected %b", e.tag, hresp, e.resp);
            end
            n_checks++;
            if (sram_cs !== e.cs) begin
                n_errors++;
                $display("FAIL %s.sram_cs: got %b expected %b", e.tag, sram_cs, e.cs);
            end
            n_checks++;
            if (sram_we !== e.we) begin
                n_errors++;
                $display("FAIL %s.sram_we: got %b expected %b", e.tag, sram_we, e.we);
            end
            if (e.cs) begin
                n_checks++;
                if (sram_addr !== e.addr) begin
                    n_errors++;
                    $display("FAIL %s.sram_addr: got %h expected %h", e.tag, sram_addr, e.addr);
                end
            end
            if (e.chk_w) begin
                n_checks++;
                if (sram_wdata !== e.wdata) begin
                    n_errors++;
                    $display("FAIL %s.sram_wdata: got %h expected %h", e.tag, sram_wdata, e.wdata);
                end
            end
            if (e.chk_r) begin
                n_checks++;
                if (hrdata !== e.rdata) begin
                    n_errors++;
                    $display("FAIL %s.hrdata: got %h expected %h", e.tag, hrdata, e.rdata);
                end
            end
        end
    end

    task automatic drv(input logic s, input logic r, input logic [1:0] t, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic e);
        hsel        = s;
        hready_in   = r;
        htrans      = t;
        hwrite      = w;
        haddr       = a;
        hwdata      = d;
        error_check = e;
    endtask

    task automatic drv_idle(input logic [31:0] d);
        drv(1'b0, 1'b1, TR_IDLE, 1'b0, 32'h0, d, 1'b0);
    endtask

    task automatic push(input string tag, input logic [1:0] st, input logic rdy, input logic resp,
                        input logic cs, input logic we, input logic [11:0] addr,
                        input logic [31:0] wd, input logic cw, input logic [31:0] rd, input logic cr);
        exp_t e;
        e.tag = tag; e.st = st; e.rdy = rdy; e.resp = resp; e.cs = cs; e.we = we;
        e.addr = addr; e.wdata = wd; e.chk_w = cw; e.rdata = rd; e.chk_r = cr;
        exp_q.push_back(e);
    endtask

    // Plain cycle with no SRAM access and no data check.
    task automatic push_quiet(input string tag, input logic [1:0] st, input logic rdy, input logic resp);
        push(tag, st, rdy, resp, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic test_reset();
        hresetn = 1'b0;
        drv_idle(32'h0);
        #3;
        n_checks++;
        if (state !== S_IDLE || hready_out !== 1'b1 || hresp !== 1'b0 || sram_cs !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: got st=%b rdy=%b resp=%b cs=%b expected st=00 rdy=1 resp=0 cs=0",
                     state, hready_out, hresp, sram_cs);
        end
`ifdef SRAM_CTR_ERR_CNT_EN
        n_checks++;
        if (err_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL reset.err_cnt: got %h expected 0000", err_cnt);
        end
`endif
        @(negedge hclk);
        hresetn = 1'b1;
        tick();
    endtask

    task automatic test_write();
        drv(1'b1, 1'b1, TR_NONSEQ, 1'b1, 32'h10, 32'h0, 1'b0);
        push_quiet("wr_ap", S_IDLE, 1'b1, 1'b0);
        tick();
        drv_idle(32'hA5A5A5A5);
        push("wr_dp", S_WRITE, 1'b1, 1'b0, 1'b1, 1'b1, 12'h004, 32'hA5A5A5A5, 1'b1, 32'h0, 1'b0);
        tick();
        drv_idle(32'h0);
        push_quiet("wr_done", S_IDLE, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_read();
        drv(1'b1, 1'b1, TR_NONSEQ, 1'b0, 32'h10, 32'h0, 1'b0);
        push("rd_ap", S_IDLE, 1'b1, 1'b0, 1'b1, 1'b0, 12'h004, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        drv_idle(32'h0);
        push("rd_dp", S_READ, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b1);
        tick();
    endtask

    task automatic test_back_to_back();
        drv(1'b1, 1'b1, TR_NONSEQ, 1'b1, 32'h20, 32'h0, 1'b0);
        push_quiet("b2b_wr_ap", S_IDLE, 1'b1, 1'b0);
        tick();
        drv(1'b1, 1'b1, TR_NONSEQ, 1'b0, 32'h20, 32'h12345678, 1'b0);
        push("b2b_wr_dp", S_WRITE, 1'b1, 1'b0, 1'b1, 1'b1, 12'h008, 32'h12345678, 1'b1, 32'h0, 1'b0);
        tick();
        // Bus is stalled by hready_out=0; the master holds its address phase.
        drv(1'b1, 1'b0, TR_NONSEQ, 1'b0, 32'h20, 32'h0, 1'b0);
        push("b2b_wr2rd", S_WR2RD, 1'b0, 1'b0, 1'b1, 1'b0, 12'h008, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        drv(1'b1, 1'b1, TR_NONSEQ, 1'b0, 32'h10, 32'h0, 1'b0);
        push("b2b_rd_dp", S_READ, 1'b1, 1'b0, 1'b1, 1'b0, 12'h004, 32'h0, 1'b0, 32'h12345678, 1'b1);
        tick();
        drv_idle(32'h0);
        push("b2b_rd2_dp", S_READ, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b1);
        tick();
        push_quiet("b2b_done", S_IDLE, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_error();
        drv(1'b1, 1'b1, TR_NONSEQ, 1'b0, 32'h2, 32'h0, 1'b1);
        push_quiet("err_ap", S_IDLE, 1'b1, 1'b0);
        tick();
        drv(1'b1, 1'b0, TR_IDLE, 1'b0, 32'h0, 32'h0, 1'b0);
        push_quiet("err_err1", S_IDLE, 1'b0, 1'b1);
        tick();
        drv_idle(32'h0);
        push_quiet("err_err2", S_IDLE, 1'b1, 1'b1);
        tick();
        push_quiet("err_okay", S_IDLE, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_seq_error();
        drv(1'b1, 1'b1, TR_SEQ, 1'b0, 32'h44, 32'h0, 1'b1);
        push_quiet("seq_err_ap", S_IDLE, 1'b1, 1'b0);
        tick();
        drv(1'b1, 1'b0, TR_IDLE, 1'b0, 32'h0, 32'h0, 1'b0);
        push_quiet("seq_err1", S_IDLE, 1'b0, 1'b1);
        tick();
        // A fresh errored transfer is accepted during the second ERROR cycle.
        drv(1'b1, 1'b1, TR_NONSEQ, 1'b1, 32'h48, 32'h0, 1'b1);
        push_quiet("seq_err2_new", S_IDLE, 1'b1, 1'b1);
        tick();
        drv(1'b1, 1'b0, TR_IDLE, 1'b0, 32'h0, 32'h0, 1'b0);
        push_quiet("seq_err1_b", S_IDLE, 1'b0, 1'b1);
        tick();
        drv(1'b1, 1'b1, TR_NONSEQ, 1'b1, 32'h30, 32'h0, 1'b0);
        push_quiet("seq_err2_wr", S_IDLE, 1'b1, 1'b1);
        tick();
        drv_idle(32'hDEADBEEF);
        push("seq_wr_dp", S_WRITE, 1'b1, 1'b0, 1'b1, 1'b1, 12'h00C, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
        tick();
    endtask

    task automatic test_busy_idle();
        drv(1'b1, 1'b1, TR_NONSEQ, 1'b1, 32'h40, 32'h0, 1'b0);
        push_quiet("busy_wr_ap", S_IDLE, 1'b1, 1'b0);
        tick();
        drv(1'b1, 1'b1, TR_BUSY, 1'b0, 32'h44, 32'h0BADF00D, 1'b0);
        push("busy_wr_dp", S_WRITE, 1'b1, 1'b0, 1'b1, 1'b1, 12'h010, 32'h0BADF00D, 1'b1, 32'h0, 1'b0);
        tick();
        drv(1'b0, 1'b1, TR_NONSEQ, 1'b0, 32'h44, 32'h0, 1'b0);
        push_quiet("busy_idle", S_IDLE, 1'b1, 1'b0);
        tick();
        drv(1'b1, 1'b0, TR_NONSEQ, 1'b0, 32'h44, 32'h0, 1'b0);
        push_quiet("nordy_idle", S_IDLE, 1'b1, 1'b0);
        tick();
        drv_idle(32'h0);
        push_quiet("busy_done", S_IDLE, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid();
        drv(1'b1, 1'b1, TR_NONSEQ, 1'b1, 32'h50, 32'h0, 1'b0);
        push_quiet("rst_wr_ap", S_IDLE, 1'b1, 1'b0);
        tick();
        drv(1'b1, 1'b1, TR_NONSEQ, 1'b0, 32'h50, 32'hCAFEF00D, 1'b0);
        push("rst_wr_dp", S_WRITE, 1'b1, 1'b0, 1'b1, 1'b1, 12'h014, 32'hCAFEF00D, 1'b1, 32'h0, 1'b0);
        tick();
        drv(1'b1, 1'b0, TR_NONSEQ, 1'b0, 32'h50, 32'h0, 1'b0);
        n_checks++;
        if (state !== S_WR2RD || sram_cs !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_pre: got st=%b cs=%b expected st=11 cs=1", state, sram_cs);
        end
        hresetn = 1'b0;
        #1;
        n_checks++;
        if (state !== S_IDLE || hready_out !== 1'b1 || hresp !== 1'b0 || sram_cs !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid: got st=%b rdy=%b resp=%b cs=%b expected st=00 rdy=1 resp=0 cs=0",
                     state, hready_out, hresp, sram_cs);
        end
        @(negedge hclk);
        hresetn = 1'b1;
        tick();
        drv_idle(32'h0);
        push_quiet("rst_dropped", S_IDLE, 1'b1, 1'b0);
        tick();
        drv(1'b1, 1'b1, TR_NONSEQ, 1'b0, 32'h50, 32'h0, 1'b0);
        push("rst_rd_ap", S_IDLE, 1'b1, 1'b0, 1'b1, 1'b0, 12'h014, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        drv_idle(32'h0);
        push("rst_rd_dp", S_READ, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 32'hCAFEF00D, 1'b1);
        tick();
    endtask

`ifdef SRAM_CTR_ERR_CNT_EN
    task automatic one_error();
        drv(1'b1, 1'b1, TR_NONSEQ, 1'b0, 32'h6, 32'h0, 1'b1);
        tick();
        drv(1'b1, 1'b0, TR_IDLE, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        drv_idle(32'h0);
        tick();
    endtask

    task automatic test_err_cnt();
        hresetn = 1'b0;
        #1;
        @(negedge hclk);
        hresetn = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) one_error();
        n_checks++;
        if (err_cnt !== 16'd3) begin
            n_errors++;
            $display("FAIL err_cnt_3: got %h expected 0003", err_cnt);
        end
        @(negedge hclk);
        force dut.err_cnt_q = 16'hFFFF;
        #1;
        release dut.err_cnt_q;
        tick();
        one_error();
        n_checks++;
        if (err_cnt !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL err_cnt_sat: got %h expected ffff", err_cnt);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_error();
        test_seq_error();
        test_busy_idle();
        test_reset_mid();
`ifdef SRAM_CTR_ERR_CNT_EN
        test_err_cnt();
`endif
        @(negedge hclk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
